// File: rtl/sys_bus_pkg.sv
// Shared types and address map for the two-master system bus arbiter.
package sys_bus_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef enum logic [1:0] {REG_MEM, REG_IO1, REG_IO2, REG_NONE} region_t;

  localparam logic [31:0] MEM_BASE  = 32'h0000_0000;
  localparam logic [31:0] MEM_LIMIT = 32'h0000_00FC;
  localparam logic [31:0] IO1_BASE  = 32'h0000_0800;
  localparam logic [31:0] IO1_LIMIT = 32'h0000_080C;
  localparam logic [31:0] IO2_BASE  = 32'h0000_0900;
  localparam logic [31:0] IO2_LIMIT = 32'h0000_090C;

  localparam int unsigned WAIT_W = 8;

  // Inclusive on both ends so the region limits themselves are mapped.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/sys_bus_arbiter_if.sv
// Master-side handshakes plus shared bus signals of sys_bus_arbiter.
// m0_lock/m1_lock exist only when SYS_BUS_LOCK_EN is defined.
interface sys_bus_arbiter_if;

  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic        m0_err;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic        m1_err;
  logic [31:0] m1_rdata;

  logic [31:0] bus_a;
  logic [31:0] bus_wd;
  logic        bus_we;
  logic [31:0] bus_rd;
  logic        gnt_id;
  logic        busy;

`ifdef SYS_BUS_LOCK_EN
  logic        m0_lock;
  logic        m1_lock;
`endif

  modport slave (
`ifdef SYS_BUS_LOCK_EN
    input  m0_lock, m1_lock,
`endif
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  bus_rd,
    output m0_ack, m0_err, m0_rdata,
    output m1_ack, m1_err, m1_rdata,
    output bus_a, bus_wd, bus_we, gnt_id, busy
  );

  modport master (
`ifdef SYS_BUS_LOCK_EN
    output m0_lock, m1_lock,
`endif
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output bus_rd,
    input  m0_ack, m0_err, m0_rdata,
    input  m1_ack, m1_err, m1_rdata,
    input  bus_a, bus_wd, bus_we, gnt_id, busy
  );

endinterface

// File: rtl/sys_bus_arbiter_lookup.sv
// Combinational address decode: region code and wait-state count.
module bus_region_lookup
  import sys_bus_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 2
) (
  input  logic [31:0]       addr,
  output region_t           region,
  output logic [WAIT_W-1:0] wait_cnt
);

  always_comb begin
    region   = REG_NONE;
    wait_cnt = '0;
    if (in_range(addr, MEM_BASE, MEM_LIMIT)) begin
      region   = REG_MEM;
      wait_cnt = WAIT_W'(MEM_WAIT);
    end else if (in_range(addr, IO1_BASE, IO1_LIMIT)) begin
      region   = REG_IO1;
      wait_cnt = WAIT_W'(IO_WAIT);
    end else if (in_range(addr, IO2_BASE, IO2_LIMIT)) begin
      region   = REG_IO2;
      wait_cnt = WAIT_W'(IO_WAIT);
    end
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Round-robin two-master system bus arbiter with per-region wait states.
// Define SYS_BUS_LOCK_EN to add m0_lock/m1_lock back-to-back grant locking.
module sys_bus_arbiter
  import sys_bus_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  sys_bus_arbiter_if.slave sb
);

  state_t            state, state_nxt;
  logic [1:0]        req;
  logic              do_grant;
  logic              sel;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_we;
  region_t           lk_region;
  logic [WAIT_W-1:0] lk_wait;
  logic              lk_mapped;

  logic [WAIT_W-1:0] cnt;
  logic              we_r;
  logic              err_r;
  logic              gnt_r;
  logic              last_r;
  logic [31:0]       rd_r;
  logic [31:0]       a_r;
  logic [31:0]       wd_r;
`ifdef SYS_BUS_LOCK_EN
  logic              lock_r;
`endif

  assign req = {sb.m1_req, sb.m0_req};

  always_comb begin
    do_grant = 1'b0;
    sel      = 1'b0;
    if (state == IDLE) begin
`ifdef SYS_BUS_LOCK_EN
      if (lock_r && req[last_r]) begin
        do_grant = 1'b1;
        sel      = last_r;
      end else
`endif
      if (&req) begin
        do_grant = 1'b1;
        sel      = ~last_r;
      end else if (req[0]) begin
        do_grant = 1'b1;
        sel      = 1'b0;
      end else if (req[1]) begin
        do_grant = 1'b1;
        sel      = 1'b1;
      end
    end
  end

  assign sel_addr  = sel ? sb.m1_addr  : sb.m0_addr;
  assign sel_wdata = sel ? sb.m1_wdata : sb.m0_wdata;
  assign sel_we    = sel ? sb.m1_we    : sb.m0_we;

  bus_region_lookup #(
    .MEM_WAIT (MEM_WAIT),
    .IO_WAIT  (IO_WAIT)
  ) u_lookup (
    .addr     (sel_addr),
    .region   (lk_region),
    .wait_cnt (lk_wait)
  );

  assign lk_mapped = (lk_region != REG_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    sb.bus_we   = 1'b0;
    sb.busy     = 1'b0;
    sb.m0_ack   = 1'b0;
    sb.m0_err   = 1'b0;
    sb.m0_rdata = '0;
    sb.m1_ack   = 1'b0;
    sb.m1_err   = 1'b0;
    sb.m1_rdata = '0;
    case (state)
      IDLE: begin
        if (do_grant) state_nxt = lk_mapped ? ACCESS : DONE;
      end
      ACCESS: begin
        sb.busy = 1'b1;
        if (cnt == '0) begin
          sb.bus_we = we_r;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (gnt_r) begin
          sb.m1_ack   = 1'b1;
          sb.m1_err   = err_r;
          sb.m1_rdata = rd_r;
        end else begin
          sb.m0_ack   = 1'b1;
          sb.m0_err   = err_r;
          sb.m0_rdata = rd_r;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // gnt_id resets to 0 while last_r resets to 1 so M0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      we_r   <= 1'b0;
      err_r  <= 1'b0;
      gnt_r  <= 1'b0;
      last_r <= 1'b1;
      rd_r   <= '0;
      a_r    <= '0;
      wd_r   <= '0;
`ifdef SYS_BUS_LOCK_EN
      lock_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef SYS_BUS_LOCK_EN
          lock_r <= 1'b0;
`endif
          if (do_grant) begin
            a_r    <= sel_addr;
            wd_r   <= sel_wdata;
            we_r   <= sel_we;
            gnt_r  <= sel;
            last_r <= sel;
            cnt    <= lk_wait;
            err_r  <= ~lk_mapped;
            rd_r   <= '0;
          end
        end
        ACCESS: begin
          if (cnt != '0) cnt  <= cnt - 1'b1;
          else           rd_r <= we_r ? '0 : sb.bus_rd;
        end
        DONE: begin
`ifdef SYS_BUS_LOCK_EN
          lock_r <= gnt_r ? sb.m1_lock : sb.m0_lock;
`endif
        end
        default: ;
      endcase
    end
  end

  assign sb.bus_a  = a_r;
  assign sb.bus_wd = wd_r;
  assign sb.gnt_id = gnt_r;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Directed scoreboard bench for sys_bus_arbiter (lock steps run when SYS_BUS_LOCK_EN is defined).
module tb_sys_bus_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lock;
    int          lat;
    int          we_lat;
  } op_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we_lat;
  } exp_t;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic [31:0] rd_const = '0;
  int          checks    = 0;
  int          errors    = 0;
  int          cyc       = 0;
  int          we_pulses = 0;

  op_t  prog0[$];
  op_t  prog1[$];
  exp_t sb0[$];
  exp_t sb1[$];
  int   order_q[$];
  logic active[2];
  logic started[2];
  int   start_at[2];
  int   issue_cyc[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sys_bus_arbiter_if bif();
  assign bif.bus_rd = rd_const;

  sys_bus_arbiter #(.MEM_WAIT(0), .IO_WAIT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (bif.slave)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic unmapped_model(input logic [31:0] a);
    return !((a <= 32'h0FC) || (a >= 32'h800 && a <= 32'h80C) ||
             (a >= 32'h900 && a <= 32'h90C));
  endfunction

  function automatic op_t mk(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic lock,
                             input int lat, input int we_lat);
    op_t o;
    o.we = we; o.addr = addr; o.wdata = wdata; o.lock = lock;
    o.lat = lat; o.we_lat = we_lat;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic req, input op_t o);
    if (k == 0) begin
      bif.m0_req = req; bif.m0_we = o.we; bif.m0_addr = o.addr; bif.m0_wdata = o.wdata;
`ifdef SYS_BUS_LOCK_EN
      bif.m0_lock = o.lock;
`endif
    end else begin
      bif.m1_req = req; bif.m1_we = o.we; bif.m1_addr = o.addr; bif.m1_wdata = o.wdata;
`ifdef SYS_BUS_LOCK_EN
      bif.m1_lock = o.lock;
`endif
    end
  endtask

  task automatic start_next(input int k);
    op_t  o;
    exp_t e;
    o = mk(1'b0, '0, '0, 1'b0, 0, 0);
    if ((k == 0 && prog0.size() == 0) || (k == 1 && prog1.size() == 0)) begin
      drive(k, 1'b0, o);
      active[k] = 1'b0;
      return;
    end
    if (k == 0) o = prog0.pop_front();
    else        o = prog1.pop_front();
    drive(k, 1'b1, o);
    e.we     = o.we;
    e.addr   = o.addr;
    e.wdata  = o.wdata;
    e.err    = unmapped_model(o.addr);
    e.rdata  = (o.we || e.err) ? 32'h0 : rd_const;
    e.lat    = o.lat;
    e.we_lat = o.we_lat;
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    issue_cyc[k] = cyc;
    active[k]    = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_m0_ack"},   {31'b0, bif.m0_ack}, 0);
    chk({tag, "_m0_err"},   {31'b0, bif.m0_err}, 0);
    chk({tag, "_m0_rdata"}, bif.m0_rdata, 0);
    chk({tag, "_m1_ack"},   {31'b0, bif.m1_ack}, 0);
    chk({tag, "_m1_err"},   {31'b0, bif.m1_err}, 0);
    chk({tag, "_m1_rdata"}, bif.m1_rdata, 0);
    chk({tag, "_bus_a"},    bif.bus_a, 0);
    chk({tag, "_bus_wd"},   bif.bus_wd, 0);
    chk({tag, "_bus_we"},   {31'b0, bif.bus_we}, 0);
    chk({tag, "_gnt_id"},   {31'b0, bif.gnt_id}, 0);
    chk({tag, "_busy"},     {31'b0, bif.busy}, 0);
  endtask

  task automatic monitor(output logic ackd0, output logic ackd1);
    exp_t e;
    int   k;
    logic a[2];
    a[0] = bif.m0_ack;
    a[1] = bif.m1_ack;
    ackd0 = a[0];
    ackd1 = a[1];
    if (bif.bus_we) begin
      we_pulses++;
      if (order_q.size() == 0) chk("bus_we_unexpected", 1, 0);
      else begin
        k = order_q[0];
        if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0))
          chk("bus_we_no_txn", 1, 0);
        else begin
          if (k == 0) e = sb0[0];
          else        e = sb1[0];
          chk("bus_a", bif.bus_a, e.addr);
          chk("bus_wd", bif.bus_wd, e.wdata);
          chk("busy_at_we", {31'b0, bif.busy}, 1);
          if (e.we_lat > 0) chk("bus_we_cycle", cyc - issue_cyc[k], e.we_lat);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (a[i]) begin
        chk("ack_exclusive", {31'b0, a[1-i]}, 0);
        if (order_q.size() == 0) chk("ack_unexpected", 1, 0);
        else chk("grant_order", i, order_q.pop_front());
        if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0))
          chk("ack_no_txn", 1, 0);
        else begin
          if (i == 0) e = sb0.pop_front();
          else        e = sb1.pop_front();
          chk("gnt_id", {31'b0, bif.gnt_id}, i);
          chk("err", {31'b0, (i == 0) ? bif.m0_err : bif.m1_err}, {31'b0, e.err});
          chk("rdata", (i == 0) ? bif.m0_rdata : bif.m1_rdata, e.rdata);
          chk("other_err", {31'b0, (i == 0) ? bif.m1_err : bif.m0_err}, 0);
          chk("other_rdata", (i == 0) ? bif.m1_rdata : bif.m0_rdata, 0);
          chk("busy_in_done", {31'b0, bif.busy}, 0);
          chk("bus_we_pulses", we_pulses, (e.we && !e.err) ? 1 : 0);
          if (e.lat > 0) chk("ack_latency", cyc - issue_cyc[i], e.lat);
        end
        we_pulses = 0;
      end
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run(input int budget);
    int   n;
    logic ackd[2];
    n = 0;
    we_pulses = 0;
    for (int k = 0; k < 2; k++) begin
      started[k] = 1'b0;
      active[k]  = 1'b0;
      if (start_at[k] == 0) begin
        started[k] = 1'b1;
        start_next(k);
      end
    end
    while (n < budget && (active[0] || active[1] || !started[0] || !started[1])) begin
      @(negedge clk);
      monitor(ackd[0], ackd[1]);
      @(posedge clk);
      #1;
      n++;
      for (int k = 0; k < 2; k++) begin
        if (ackd[k]) start_next(k);
        else if (!started[k] && n >= start_at[k]) begin
          started[k] = 1'b1;
          start_next(k);
        end
      end
    end
    chk("run_complete", {30'b0, active[1] | ~started[1], active[0] | ~started[0]}, 0);
    chk("scoreboard_drained", sb0.size() + sb1.size() + order_q.size(), 0);
    sb0.delete();
    sb1.delete();
    order_q.delete();
  endtask

  task automatic do_reset();
    op_t z;
    z = mk(1'b0, '0, '0, 1'b0, 0, 0);
    rst_n = 1'b0;
    drive(0, 1'b0, z);
    drive(1, 1'b0, z);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    op_t  z;
    logic seen;
    z = mk(1'b0, '0, '0, 1'b0, 0, 0);
    drive(0, 1'b0, z);
    drive(1, 1'b0, z);

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single mapped memory read, defaults: ack on cycle 3
    rd_const = 32'hDEAD_BEEF;
    prog0.push_back(mk(1'b0, 32'h004, 32'h0, 1'b0, 2, 0));
    order_q = '{0};
    start_at = '{0, 0};
    run(20);

    // IO write: bus_we on cycle 4, ack on cycle 5
    prog1.push_back(mk(1'b1, 32'h804, 32'h5, 1'b0, 4, 3));
    order_q = '{1};
    run(20);

    // Both masters from reset, three writes each: strict alternation
    do_reset();
    rd_const = 32'h0BAD_F00D;
    prog0.push_back(mk(1'b1, 32'h000, 32'hA0, 1'b0, 0, 0));
    prog0.push_back(mk(1'b1, 32'h0FC, 32'hA1, 1'b0, 0, 0));
    prog0.push_back(mk(1'b1, 32'h008, 32'hA2, 1'b0, 0, 0));
    prog1.push_back(mk(1'b1, 32'h800, 32'hB0, 1'b0, 0, 0));
    prog1.push_back(mk(1'b1, 32'h80C, 32'hB1, 1'b0, 0, 0));
    prog1.push_back(mk(1'b1, 32'h90C, 32'hB2, 1'b0, 0, 0));
    order_q = '{0, 1, 0, 1, 0, 1};
    run(80);

    // Region boundaries and unmapped reads on M0
    rd_const = 32'h1234_5678;
    prog0.push_back(mk(1'b0, 32'h100, 32'h0, 1'b0, 1, 0));
    prog0.push_back(mk(1'b0, 32'h810, 32'h0, 1'b0, 1, 0));
    prog0.push_back(mk(1'b0, 32'h0FC, 32'h0, 1'b0, 2, 0));
    prog0.push_back(mk(1'b0, 32'h90C, 32'h0, 1'b0, 4, 0));
    prog0.push_back(mk(1'b0, 32'h800, 32'h0, 1'b0, 4, 0));
    order_q = '{0, 0, 0, 0, 0};
    run(60);

    // Unmapped write never strobes bus_we; mapped IO write after it does
    prog1.push_back(mk(1'b1, 32'h100, 32'h99, 1'b0, 1, 0));
    prog1.push_back(mk(1'b1, 32'h90C, 32'h42, 1'b0, 4, 3));
    order_q = '{1, 1};
    run(40);

    // Reset in the middle of an IO wait drops the transaction
    drive(1, 1'b1, mk(1'b1, 32'h808, 32'h77, 1'b0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("busy_before_reset", {31'b0, bif.busy}, 1);
    chk("bus_a_before_reset", bif.bus_a, 32'h808);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    drive(1, 1'b0, z);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | bif.m0_ack | bif.m1_ack;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen = seen | bif.m0_ack | bif.m1_ack | bif.bus_we;
    end
    chk("no_ack_after_midreset", {31'b0, seen}, 0);
    @(posedge clk);
    #1;

    // After reset the tie goes to M0
    rd_const = 32'hCAFE_0001;
    prog0.push_back(mk(1'b0, 32'h008, 32'h0, 1'b0, 0, 0));
    prog1.push_back(mk(1'b0, 32'h80C, 32'h0, 1'b0, 0, 0));
    order_q = '{0, 1};
    run(40);

`ifdef SYS_BUS_LOCK_EN
    // Locked read-modify-write by M1 keeps M0 out until the write completes
    rd_const = 32'h0000_00F0;
    prog1.push_back(mk(1'b0, 32'h900, 32'h0, 1'b1, 0, 0));
    prog1.push_back(mk(1'b1, 32'h900, 32'hC3, 1'b0, 0, 0));
    prog0.push_back(mk(1'b1, 32'h904, 32'hD0, 1'b0, 0, 0));
    order_q = '{1, 1, 0};
    start_at = '{2, 0};
    run(60);
    start_at = '{0, 0};
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
